// File: rtl/char_rd_if.sv
// char_rd_if
// Bundles the two requester ports and the RAM read port of the character
// RAM read arbiter.
//   req0/addr0/ack0/rvalid0/rdata0 : port 0 (scanout engine) request and response
//   req1/addr1/ack1/rvalid1/rdata1 : port 1 (CPU/debug reader) request and response
//   ram_raddr/ram_re/ram_rdata     : single shared RAM/ROM read port
// Modports:
//   slave  : the arbiter's view
//   master : the requesters and the RAM together (the environment)
interface char_rd_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8
);
   logic                  req0;
   logic [ADDR_WIDTH-1:0] addr0;
   logic                  ack0;
   logic                  rvalid0;
   logic [DATA_WIDTH-1:0] rdata0;

   logic                  req1;
   logic [ADDR_WIDTH-1:0] addr1;
   logic                  ack1;
   logic                  rvalid1;
   logic [DATA_WIDTH-1:0] rdata1;

   logic [ADDR_WIDTH-1:0] ram_raddr;
   logic                  ram_re;
   logic [DATA_WIDTH-1:0] ram_rdata;

   modport slave (
      input  req0, addr0, req1, addr1, ram_rdata,
      output ack0, rvalid0, rdata0, ack1, rvalid1, rdata1, ram_raddr, ram_re
   );

   modport master (
      output req0, addr0, req1, addr1, ram_rdata,
      input  ack0, rvalid0, rdata0, ack1, rvalid1, rdata1, ram_raddr, ram_re
   );
endinterface

// File: rtl/char_rd_arbiter.sv
// char_rd_arbiter
// Shares the single read port of the character RAM/font ROM between two
// requesters. At most one read is granted per cycle. A tag pipeline, as deep
// as the RAM read latency, remembers which port issued each in-flight read,
// so the returned word can be steered back with a one-cycle valid pulse.
// Ports:
//   rclk   : clock, all state changes on the rising edge
//   rst_n  : asynchronous reset, active low
//   bus    : char_rd_if.slave (requester ports and RAM read port)
// Parameters:
//   DATA_WIDTH, ADDR_WIDTH : RAM word and address widths
//   RAM_LATENCY            : cycles from a sampled read to valid ram_rdata (0..4)
// Build option:
//   PRIO0_EN : when defined, port 0 always wins contention (fixed priority)
//              instead of round-robin, so scanout can never be stalled.
module char_rd_arbiter #(
   parameter int DATA_WIDTH  = 8,
   parameter int ADDR_WIDTH  = 8,
   parameter int RAM_LATENCY = 1
) (
   input logic     rclk,
   input logic     rst_n,
   char_rd_if.slave bus
);

   logic                  grant0;
   logic                  grant1;
   logic                  grant_any;
   logic [ADDR_WIDTH-1:0] raddr_q;
   logic                  ret_valid;
   logic                  ret_port;

`ifdef PRIO0_EN
   // Fixed priority: port 1 only gets the RAM in cycles where port 0 is idle.
   // Grants are suppressed while reset is asserted so ack stays low.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (rst_n) begin
         grant0 = bus.req0;
         grant1 = bus.req1 & ~bus.req0;
      end
   end
`else
   logic last_grant;

   // Round-robin: on contention the port that did not win last time is
   // served. A lone requester is always served, giving back-to-back grants.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (rst_n) begin
         if (bus.req0 && bus.req1) begin
            grant0 = last_grant;
            grant1 = ~last_grant;
         end else begin
            grant0 = bus.req0;
            grant1 = bus.req1;
         end
      end
   end

   // Remember the winner of every grant. Reset to 1 so that port 0 wins the
   // first contention after reset.
   always_ff @(posedge rclk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= 1'b1;
      end else if (grant0) begin
         last_grant <= 1'b0;
      end else if (grant1) begin
         last_grant <= 1'b1;
      end
   end
`endif

   assign grant_any = grant0 | grant1;
   assign bus.ack0  = grant0;
   assign bus.ack1  = grant1;
   assign bus.ram_re = grant_any;

   // The RAM address follows the granted port; when idle it holds the last
   // granted address so the RAM address bus does not toggle needlessly.
   assign bus.ram_raddr = grant1 ? bus.addr1 :
                          grant0 ? bus.addr0 : raddr_q;

   // Capture the address of every granted read for the idle hold value.
   always_ff @(posedge rclk or negedge rst_n) begin
      if (!rst_n) begin
         raddr_q <= '0;
      end else if (grant_any) begin
         raddr_q <= bus.ram_raddr;
      end
   end

   generate
      if (RAM_LATENCY == 0) begin : g_bypass
         // Combinational RAM: data belongs to the read granted this very cycle.
         assign ret_valid = grant_any;
         assign ret_port  = grant1;
      end else begin : g_pipe
         logic [RAM_LATENCY-1:0] tag_valid;
         logic [RAM_LATENCY-1:0] tag_port;

         // Tag shift register: stage 0 is loaded at the grant edge and the
         // tag in the last stage lines up with the data on ram_rdata.
         // Reset drops every in-flight tag so no stale response escapes.
         always_ff @(posedge rclk or negedge rst_n) begin
            if (!rst_n) begin
               tag_valid <= '0;
               tag_port  <= '0;
            end else begin
               tag_valid[0] <= grant_any;
               tag_port[0]  <= grant1;
               for (int i = 1; i < RAM_LATENCY; i++) begin
                  tag_valid[i] <= tag_valid[i-1];
                  tag_port[i]  <= tag_port[i-1];
               end
            end
         end

         assign ret_valid = tag_valid[RAM_LATENCY-1];
         assign ret_port  = tag_port[RAM_LATENCY-1];
      end
   endgenerate

   // Return path: register the RAM word into the owning port's data register
   // and pulse its valid for one cycle. Data registers hold between pulses.
   always_ff @(posedge rclk or negedge rst_n) begin
      if (!rst_n) begin
         bus.rvalid0 <= 1'b0;
         bus.rvalid1 <= 1'b0;
         bus.rdata0  <= '0;
         bus.rdata1  <= '0;
      end else begin
         bus.rvalid0 <= ret_valid & ~ret_port;
         bus.rvalid1 <= ret_valid & ret_port;
         if (ret_valid && !ret_port) begin
            bus.rdata0 <= bus.ram_rdata;
         end
         if (ret_valid && ret_port) begin
            bus.rdata1 <= bus.ram_rdata;
         end
      end
   end

endmodule
